// File: rtl/jpeg_ctrl_pkg.sv
// jpeg_ctrl_pkg: shared sequencer states, block size and zigzag index-to-raster table
package jpeg_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PATCH, FLUSH, DONE} state_t;
  localparam int BLK_ELEMS = 64;
  localparam logic [5:0] ZZ [BLK_ELEMS] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/zigzag_lut.sv
// zigzag_lut: combinational 6-bit zigzag index to 6-bit raster address map
module zigzag_lut
  import jpeg_ctrl_pkg::*;
(
  input  logic [5:0] idx,
  output logic [5:0] addr
);
  assign addr = ZZ[idx];
endmodule

// File: rtl/databuffer_seq_ctrl.sv
// databuffer_seq_ctrl: sequences bulk load, patch writes and bulk output of the 64x8 block buffer
module databuffer_seq_ctrl
  import jpeg_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = BLK_ELEMS,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  blk_in_valid,
  output logic                  blk_in_ready,
  input  logic [6:0]            cfg_patch_len,
  input  logic                  cfg_zigzag,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  buf_input_enable,
  output logic                  buf_input_data_enable,
  output logic [ADDR_WIDTH-1:0] buf_input_data_address,
  output logic [DATA_WIDTH-1:0] buf_input_address_data,
  output logic                  buf_output_enable,
  output logic                  blk_out_valid,
  input  logic                  blk_out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  blocks_done
);
  localparam logic [6:0] MAX_LEN = 7'(DEPTH);
  state_t state, state_nx;
  logic [5:0] idx, zz_addr;
  logic [6:0] len, len_in;
  logic zz, rst_q, en, acc_in, acc_wr, acc_out, last;
  assign en = !reset && !rst_q;
  assign len_in = cfg_patch_len > MAX_LEN ? MAX_LEN : cfg_patch_len;
  assign last = {1'b0, idx} == len - 7'd1;
  assign busy = state != IDLE;
  assign blk_in_ready = en && state == IDLE;
  assign wr_ready = en && state == PATCH;
  assign buf_output_enable = en && state == FLUSH;
  assign blk_out_valid = en && state == DONE;
  assign acc_in = blk_in_ready && blk_in_valid;
  assign acc_wr = wr_ready && wr_valid;
  assign acc_out = blk_out_valid && blk_out_ready;
  assign buf_input_enable = acc_in;
  assign buf_input_data_enable = acc_wr;
  assign buf_input_data_address = acc_wr ? ADDR_WIDTH'(zz ? zz_addr : idx) : '0;
  assign buf_input_address_data = acc_wr ? wr_data : '0;
  zigzag_lut u_zz (.idx(idx), .addr(zz_addr));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = acc_in ? (len_in != 7'd0 ? PATCH : FLUSH) : IDLE;
      PATCH:   state_nx = acc_wr && last ? FLUSH : PATCH;
      FLUSH:   state_nx = DONE;
      DONE:    state_nx = acc_out ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= '0;
      zz          <= 1'b0;
      blocks_done <= '0;
      rst_q       <= 1'b1;
    end else begin
      state <= state_nx;
      rst_q <= 1'b0;
      if (acc_in) begin
        len <= len_in;
        zz  <= cfg_zigzag;
      end
      if (acc_wr) idx <= last ? '0 : idx + 6'd1;
      if (acc_out) blocks_done <= blocks_done + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_databuffer_seq_ctrl.sv
// tb_databuffer_seq_ctrl: directed stimulus with a per-cycle behavioural model check
module tb_databuffer_seq_ctrl;
  logic clock = 0, reset = 1, blk_in_valid = 0, cfg_zigzag = 0, wr_valid = 0, blk_out_ready = 0;
  logic [6:0] cfg_patch_len = 0;
  logic [7:0] wr_data = 0;
  logic blk_in_ready, wr_ready, buf_input_enable, buf_input_data_enable, buf_output_enable, blk_out_valid, busy;
  logic [7:0] buf_input_data_address, buf_input_address_data;
  logic [15:0] blocks_done;
  logic w_blk_in_ready, w_wr_ready, w_buf_input_enable, w_buf_input_data_enable, w_buf_output_enable, w_blk_out_valid, w_busy;
  logic [7:0] w_buf_input_data_address, w_buf_input_address_data;
  logic [3:0] w_blocks_done;
  int nchk = 0, npass = 0;
  logic [7:0] bufm [64];
  int wa [$];
  int wd [$];
  bit m_on = 0, m_busy = 0, m_zz = 0, m_flush = 0, m_done = 0, m_hold = 1;
  int m_left = 0, m_k = 0;
  logic [15:0] m_cnt = 0;
  bit e_in_rdy, e_in_en, e_wr_rdy, e_wr_en, e_out_en, e_out_v, e_ok;
  logic [7:0] e_addr, e_data;

  databuffer_seq_ctrl dut (
    .clock(clock), .reset(reset), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready),
    .cfg_patch_len(cfg_patch_len), .cfg_zigzag(cfg_zigzag), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .buf_input_enable(buf_input_enable), .buf_input_data_enable(buf_input_data_enable),
    .buf_input_data_address(buf_input_data_address), .buf_input_address_data(buf_input_address_data),
    .buf_output_enable(buf_output_enable), .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
    .busy(busy), .blocks_done(blocks_done));

  databuffer_seq_ctrl #(.CNT_WIDTH(4)) dut_w (
    .clock(clock), .reset(reset), .blk_in_valid(blk_in_valid), .blk_in_ready(w_blk_in_ready),
    .cfg_patch_len(cfg_patch_len), .cfg_zigzag(cfg_zigzag), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(w_wr_ready), .buf_input_enable(w_buf_input_enable), .buf_input_data_enable(w_buf_input_data_enable),
    .buf_input_data_address(w_buf_input_data_address), .buf_input_address_data(w_buf_input_address_data),
    .buf_output_enable(w_buf_output_enable), .blk_out_valid(w_blk_out_valid), .blk_out_ready(blk_out_ready),
    .busy(w_busy), .blocks_done(w_blocks_done));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Zigzag order derived by walking anti-diagonals, alternating direction.
  function automatic int zz_of(input int n);
    int k = 0, r;
    for (int s = 0; s < 15; s++)
      for (int j = 0; j < 8; j++) begin
        r = (s % 2) ? j : 7 - j;
        if (s - r >= 0 && s - r <= 7) begin
          if (k == n) return r * 8 + (s - r);
          k++;
        end
      end
    return 0;
  endfunction

  always @(negedge clock) if (m_on) begin
    e_ok = !reset && !m_hold;
    e_in_rdy = e_ok && !m_busy;
    e_in_en = e_in_rdy && blk_in_valid;
    e_wr_rdy = e_ok && m_busy && m_left > 0;
    e_wr_en = e_wr_rdy && wr_valid;
    e_addr = e_wr_en ? 8'(m_zz ? zz_of(m_k) : m_k) : 8'd0;
    e_data = e_wr_en ? wr_data : 8'd0;
    e_out_en = !reset && m_flush;
    e_out_v = !reset && m_done;
    chk("cycle", {blk_in_ready, buf_input_enable, wr_ready, buf_input_data_enable, buf_input_data_address,
                  buf_input_address_data, buf_output_enable, blk_out_valid, busy, blocks_done},
                 {e_in_rdy, e_in_en, e_wr_rdy, e_wr_en, e_addr, e_data, e_out_en, e_out_v, m_busy, m_cnt});
    chk("cycle_w", {w_blk_in_ready, w_buf_input_enable, w_wr_ready, w_buf_input_data_enable, w_buf_input_data_address,
                    w_buf_input_address_data, w_buf_output_enable, w_blk_out_valid, w_busy, w_blocks_done},
                   {e_in_rdy, e_in_en, e_wr_rdy, e_wr_en, e_addr, e_data, e_out_en, e_out_v, m_busy, m_cnt[3:0]});
  end

  always @(posedge clock) begin
    if (reset) begin
      m_on = 1; m_busy = 0; m_left = 0; m_k = 0; m_flush = 0; m_done = 0; m_cnt = 0; m_hold = 1; m_zz = 0;
    end else if (m_on) begin
      m_hold = 0;
      if (e_in_en) begin
        m_busy = 1; m_zz = cfg_zigzag; m_k = 0;
        m_left = cfg_patch_len > 64 ? 64 : int'(cfg_patch_len);
        m_flush = m_left == 0;
      end else if (e_wr_en) begin
        m_k++; m_left--; m_flush = m_left == 0;
      end else if (m_flush) begin
        m_flush = 0; m_done = 1;
      end else if (m_done && blk_out_ready) begin
        m_done = 0; m_busy = 0; m_cnt++;
      end
    end
  end

  always @(posedge clock) if (buf_input_data_enable) begin
    bufm[buf_input_data_address[5:0]] <= buf_input_address_data;
    wa.push_back(int'(buf_input_data_address));
    wd.push_back(int'(buf_input_address_data));
  end

  task automatic step; @(posedge clock); #1; endtask
  task automatic smp; @(negedge clock); endtask

  task automatic send_block(input int len, input bit z);
    int n = 0;
    blk_in_valid = 1; cfg_patch_len = 7'(len); cfg_zigzag = z;
    smp;
    while (!blk_in_ready && n < 50) begin step; smp; n++; end
    if (!blk_in_ready) chk("in_timeout", 0, 1);
    step;
    blk_in_valid = 0; cfg_patch_len = 0; cfg_zigzag = 0;
  endtask

  task automatic wr(input bit v, input logic [7:0] d);
    wr_valid = v; wr_data = d;
    step;
    wr_valid = 0;
  endtask

  task automatic finish_block(input int hold);
    int n = 0;
    blk_out_ready = 0;
    smp;
    while (!blk_out_valid && n < 200) begin step; smp; n++; end
    if (!blk_out_valid) chk("out_timeout", 0, 1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {blk_out_valid, blk_in_ready}, 2'b10);
      step; smp;
    end
    step;
    blk_out_ready = 1;
    step;
    blk_out_ready = 0;
  endtask

  initial begin
    int zz6 [6] = '{0, 1, 8, 16, 9, 2};
    int st [6] = '{1, 0, 0, 1, 0, 1};
    int n;
    step; step;
    smp;
    chk("rst_busy", busy, 0);
    chk("rst_cnt", blocks_done, 0);
    chk("rst_in_ready", blk_in_ready, 0);
    step;
    reset = 0;
    step;
    // load only, len 0
    blk_in_valid = 1; cfg_patch_len = 0; blk_out_ready = 1;
    smp; chk("load_in_en", buf_input_enable, 1);
    step; blk_in_valid = 0;
    smp; chk("load_out_en", buf_output_enable, 1); chk("load_in_ready", blk_in_ready, 0);
    step;
    smp; chk("load_out_valid", blk_out_valid, 1);
    step; blk_out_ready = 0;
    smp; chk("load_cnt", blocks_done, 1); chk("load_busy", busy, 0);
    step;
    // raster patch
    wa.delete(); wd.delete();
    send_block(4, 0);
    for (int i = 0; i < 4; i++) wr(1, 8'hA0 + 8'(i));
    smp; chk("raster_flush", buf_output_enable, 1);
    step;
    finish_block(0);
    chk("raster_n", wa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("raster_addr", wa[i], i);
      chk("raster_data", wd[i], 'hA0 + i);
      chk("raster_buf", bufm[i], 'hA0 + i);
    end
    // zigzag len 6
    wa.delete(); wd.delete();
    send_block(6, 1);
    for (int i = 0; i < 6; i++) wr(1, 8'(i));
    finish_block(0);
    chk("zz6_n", wa.size(), 6);
    for (int i = 0; i < 6; i++) chk("zz6_addr", wa[i], zz6[i]);
    // zigzag len 64
    wa.delete(); wd.delete();
    send_block(64, 1);
    for (int i = 0; i < 64; i++) wr(1, 8'(i));
    finish_block(0);
    chk("zz64_n", wa.size(), 64);
    chk("zz64_a61", wa[61], 55);
    chk("zz64_a62", wa[62], 62);
    chk("zz64_a63", wa[63], 63);
    // stalls
    wa.delete(); wd.delete();
    send_block(3, 0);
    for (int i = 0; i < 6; i++) wr(st[i] != 0, 8'h30 + 8'(i));
    finish_block(5);
    chk("stall_n", wa.size(), 3);
    chk("stall_a0", wa[0], 0); chk("stall_a1", wa[1], 1); chk("stall_a2", wa[2], 2);
    chk("stall_d0", wd[0], 'h30); chk("stall_d1", wd[1], 'h33); chk("stall_d2", wd[2], 'h35);
    // clamp
    wa.delete(); wd.delete();
    send_block(100, 0);
    for (int i = 0; i < 65; i++) wr(1, 8'(i));
    finish_block(0);
    chk("clamp_n", wa.size(), 64);
    chk("clamp_a63", wa[63], 63);
    smp; chk("cnt_before_rst", blocks_done, 6);
    step;
    // reset mid-patch
    send_block(5, 0);
    wr(1, 8'h11); wr(1, 8'h22);
    reset = 1; wr_valid = 1; wr_data = 8'h33;
    smp; chk("rst_cycle", {buf_input_data_enable, wr_ready, buf_input_enable, buf_output_enable}, 0);
    step;
    reset = 0; blk_in_valid = 1; cfg_patch_len = 2;
    smp; chk("post_rst", {busy, buf_input_enable, buf_input_data_enable, buf_output_enable, blk_in_ready}, 0);
    chk("post_rst_cnt", blocks_done, 0);
    step;
    wr_valid = 0;
    wa.delete(); wd.delete();
    send_block(2, 0);
    wr(1, 8'h44); wr(1, 8'h55);
    finish_block(0);
    chk("restart_n", wa.size(), 2);
    chk("restart_a0", wa[0], 0);
    chk("restart_d0", wd[0], 'h44);
    // wrap of the narrow counter
    blk_in_valid = 1; cfg_patch_len = 0; blk_out_ready = 1;
    n = 0;
    smp;
    while (blocks_done != 16 && n < 200) begin step; smp; n++; end
    chk("wrap_main", blocks_done, 16);
    chk("wrap_narrow", w_blocks_done, 0);
    step;
    blk_in_valid = 0;
    repeat (6) step;
    blk_out_ready = 0;
    smp; chk("drain_idle", busy, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
